wrr_arb: RTL
============

// Module: wrr_arb
// PURPOSE
//  Weighted round-robin arbiter. Successor to the single-grant rr block.
//  - N requestors, each with a programmable weight of consecutive grants.
//  - A grant is held (locked) until the consumer acks it.
//  - Ack with no grant has no effect on state.
//  Sits in front of shared resources (bus ports, FIFO write ports).
// PARAMETERS
//  N   8  number of requestors; N > 1 (static assert)
//  WW  4  weight width; weights 0..2**WW-1
//  IW  $clog2(N)  derived, width of encoded grant; not overridable
// PORTS
//  clk      in   1     clock
//  rst      in   1     reset, synchronous, active-high
//  req      in   N     request vector
//  weight   in   N*WW  per-requestor weight, requestor i at [i*WW +: WW]
//  ack      in   1     consumer accepts current gnt this cycle
//  gnt      out  N     one-hot grant, or 0
//  gnt_id   out  IW    binary index of gnt; 0 when gnt==0
//  locked   out  1     gnt is being held from an earlier cycle
// BEHAVIOUR
//  State registers:
//   ptr_r   N-bit one-hot priority pointer; reset 'b1
//   cred_r  WW-bit remaining extra grants for ptr_r owner; reset 0
//   lock_r  lock flag; reset 0
//   lgnt_r  N-bit locked grant; reset 0
//  Outputs after reset: gnt=0, gnt_id=0, locked=0 until req != 0.
//  Arbitration: combinational, 0-cycle latency.
//   - Unlocked: mask = ptr_r and all positions above it; win = lowest set
//     bit of (req & mask) if non-zero, else lowest set bit of req.
//   - gnt = lock_r ? lgnt_r : win.
//  Lock:
//   - gnt != 0 & !ack -> lock_r <= 1, lgnt_r <= gnt.
//   - ack -> lock_r <= 0.
//   - Higher-priority requests arriving while locked do not change gnt.
//  Credit/pointer update, only when ack & gnt != 0; i = granted index:
//   - eff_w = (weight[i]==0) ? 1 : weight[i]; weight is sampled here only.
//   - gnt==ptr_r & cred_r!=0: cred_r <= cred_r-1.
//     ptr_r <= (cred_r==1) ? rotl1(gnt) : ptr_r.
//   - Otherwise: cred_r <= eff_w-1.
//     ptr_r <= (eff_w==1) ? rotl1(gnt) : gnt.
//     Any unused credit of the previous owner is forfeited.
//   - rotl1: rotate left by one; bit N-1 wraps to bit 0.
//  Ack handling:
//   - ack & gnt==0: no state change. This is legal, so ack may be tied
//     high.
//   - Weight changes mid-burst take effect at the next credit reload.
//  Reset mid-operation: all state returns to reset values; a held grant
//   is dropped.
//  Assertions:
//   - $onehot0(gnt).
//   - (gnt==0) == (req==0) when unlocked.
//   - While locked, req[lgnt_r] stays high (contract on requestor).
//   - ptr_r is always one-hot.
// STRUCTURE
//  Package arb_pkg: functions rotl1, mask_left_inclusive, ffs and onehot2bin,
//   each parametrised by width; shared with rr and future arbiters.
//  Sub-module rr_pick #(N): combinational (req, ptr) -> win. Reused by the
//   other round-robin arbiters.
//  wrr_arb owns the lock and credit registers, the gnt_id encoder and the
//   assertions.
// TESTING (N=4, WW=4)
//  1. All weights 1, req=1111, ack=1 every cycle -> gnt 0001,0010,0100,1000,0001.
//  2. w0=3, others 1, req=1111, ack=1 -> gnt 0001 x3, then 0010,0100,1000,
//     then 0001 x3.
//  3. req=0001, ack=0 for 3 cycles, req[3] raised in cycle 1 -> gnt stays
//     0001 with locked=1 from cycle 1; ack in cycle 3; cycle 4 gnt=1000.
//  4. req=0, ack=1 for 5 cycles after test 1 -> gnt=0, ptr_r unchanged.
//     Then req=1111 -> first gnt equals the pre-idle pointer position.
//  5. w2=0 -> single grant per turn for 2.
//     w2=15 with req=0100 plus others -> 15 consecutive grants to 0100,
//     then rotation.
//  6. rst asserted while locked on 0100 -> next cycle locked=0; with
//     req=1111, gnt=0001.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbiter helpers: width-generic vector functions for one-hot pointers and grants.
// Vectors are carried in an ARB_MAXW-bit container; callers pass the live width.
package arb_pkg;

  localparam int unsigned ARB_MAXW = 32;

  typedef logic [ARB_MAXW-1:0] arb_vec_t;

  // All-ones over the low w bits.
  function automatic arb_vec_t width_mask(input int unsigned w);
    if (w >= ARB_MAXW) return '1;
    return (arb_vec_t'(1) << w) - arb_vec_t'(1);
  endfunction

  function automatic arb_vec_t rotl1(input arb_vec_t v, input int unsigned w);
    arb_vec_t vm;
    vm = v & width_mask(w);
    return ((vm << 1) | (vm >> (w - 1))) & width_mask(w);
  endfunction

  // For a one-hot ptr: ptr's position and every position above it.
  function automatic arb_vec_t mask_left_inclusive(input arb_vec_t ptr, input int unsigned w);
    return ~(ptr - arb_vec_t'(1)) & width_mask(w);
  endfunction

  // Isolates the lowest set bit (one-hot result, 0 if none).
  function automatic arb_vec_t ffs(input arb_vec_t v, input int unsigned w);
    arb_vec_t vm;
    vm = v & width_mask(w);
    return vm & (~vm + arb_vec_t'(1));
  endfunction

  function automatic arb_vec_t onehot2bin(input arb_vec_t v, input int unsigned w);
    arb_vec_t r;
    r = '0;
    for (int unsigned i = 0; i < ARB_MAXW; i++) begin
      if (i < w && v[i]) r = r | arb_vec_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first requestor at or above the one-hot pointer, wrapping to the lowest.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] win
);

  arb_vec_t req_w;
  arb_vec_t masked;

  assign req_w  = arb_vec_t'(req);
  assign masked = req_w & mask_left_inclusive(arb_vec_t'(ptr), N);
  assign win    = (masked != '0) ? N'(ffs(masked, N)) : N'(ffs(req_w, N));

endmodule

// File: rtl/wrr_arb.sv
// Weighted round-robin arbiter: per-requestor burst credits, grant held until acked.
module wrr_arb
  import arb_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned WW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N*WW-1:0]        weight,
  input  logic                   ack,
  output logic [N-1:0]           gnt,
  output logic [$clog2(N)-1:0]   gnt_id,
  output logic                   locked
);

  localparam int unsigned IW = $clog2(N);

  if (N < 2 || N > ARB_MAXW) begin : g_n_check
    $error("wrr_arb: N must be in 2..ARB_MAXW");
  end

  logic [N-1:0]  ptr_q, ptr_d;
  logic [WW-1:0] cred_q, cred_d;
  logic          lock_q, lock_d;
  logic [N-1:0]  lgnt_q, lgnt_d;

  logic [N-1:0]  win;
  logic [WW-1:0] w_sel;
  logic [WW-1:0] eff_w;
  logic          gnt_any;

  rr_pick #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .win (win)
  );

  assign gnt     = lock_q ? lgnt_q : win;
  assign gnt_any = (gnt != '0);
  assign gnt_id  = IW'(onehot2bin(arb_vec_t'(gnt), N));
  assign locked  = lock_q;

  // Weight of the current grantee; zero is treated as a single grant.
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt[i]) w_sel = weight[i*WW +: WW];
    end
    eff_w = (w_sel == '0) ? WW'(1) : w_sel;
  end

  always_comb begin
    ptr_d  = ptr_q;
    cred_d = cred_q;
    lock_d = lock_q;
    lgnt_d = lgnt_q;

    if (gnt_any && !ack) begin
      lock_d = 1'b1;
      lgnt_d = gnt;
    end
    if (ack) lock_d = 1'b0;

    // Pointer owner continues its burst while credit remains; anyone else reloads.
    if (ack && gnt_any) begin
      if (gnt == ptr_q && cred_q != '0) begin
        cred_d = cred_q - WW'(1);
        if (cred_q == WW'(1)) ptr_d = N'(rotl1(arb_vec_t'(gnt), N));
      end else begin
        cred_d = eff_w - WW'(1);
        ptr_d  = (eff_w == WW'(1)) ? N'(rotl1(arb_vec_t'(gnt), N)) : gnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= N'(1);
      cred_q <= '0;
      lock_q <= 1'b0;
      lgnt_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      cred_q <= cred_d;
      lock_q <= lock_d;
      lgnt_q <= lgnt_d;
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_gnt_iff_req: assert property (@(posedge clk) disable iff (rst)
                                  !lock_q |-> ((gnt == '0) == (req == '0)));
  a_lock_req_held: assert property (@(posedge clk) disable iff (rst)
                                    lock_q |-> ((req & lgnt_q) != '0));
  a_ptr_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(ptr_q));

endmodule
